brg_param: RTL and testbench
============================

BRG_PARAM -- requirements
Module: brg_param

Interface
REQ-001 SHALL provide parameter DIV_W, default 16, meaning the divisor and counter width in bits.
REQ-002 SHALL provide parameter OSR_LOG2, default 4, meaning the log2 of the rx oversample ratio (range 0..DIV_W-1).
REQ-003 SHALL provide parameter DEFAULT_DIV, default 16'h028B, meaning the divisor D loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: counters run when high and hold when low.
REQ-007 SHALL have port div_load, input, 1 bit: single-cycle strobe that captures div_in into the pending register.
REQ-008 SHALL have port div_in, input, DIV_W bits: new divisor value.
REQ-009 SHALL have port rx_resync, input, 1 bit: single-cycle strobe that realigns the rx counter, e.g. on a start-bit edge.
REQ-010 SHALL have port tx_enable, output, 1 bit: one-cycle tx bit-rate pulse.
REQ-011 SHALL have port rx_enable, output, 1 bit: one-cycle rx oversample pulse.
REQ-012 SHALL have port div_pending, output, 1 bit: high while a loaded divisor awaits application.

Function
REQ-013 SHALL hold an active divisor D and derive R = D >> OSR_LOG2 (zero-extended, DIV_W bits).
REQ-014 SHALL run the tx counter as follows while enable=1: decrement each cycle; at 0, reload D; tx_enable = enable AND (tx counter == 0), giving a period of D+1 cycles (D=0 gives a pulse every cycle).
REQ-015 SHALL run the rx counter identically with R: rx_enable = enable AND (rx counter == 0), giving a period of R+1 cycles.
REQ-016 SHALL freeze both counters and force both pulses low while enable=0; on re-enable, counting resumes from the held values.
REQ-017 SHALL, on div_load, write div_in to the pending register and set div_pending on the next edge; a later load overwrites the pending value (last wins).
REQ-018 SHALL apply a pending divisor while enable=1 at the tx terminal cycle (tx counter == 0): D <= pending, tx counter <= new D, rx counter <= new R, div_pending <= 0.
REQ-019 SHALL apply a pending divisor while enable=0 on the following edge: D <= pending, and both counters reload with the new D and R.
REQ-020 SHALL treat a div_load in the same cycle as a tx terminal as not yet pending: it is applied at the next terminal, and the current terminal reloads the old D.
REQ-021 SHALL, on rx_resync while enable=1, set the rx counter to R >> 1 on the next edge (mid-bit alignment); resync overrides the rx terminal reload and does not affect the tx counter.
REQ-022 SHALL give priority to a divisor application over rx_resync when both occur in the same cycle.
REQ-023 SHALL keep outputs combinational from registered state only, with no input-to-output path except via enable.

Reset
REQ-024 SHALL, while rst_n=0, set asynchronously: D=DEFAULT_DIV, pending=DEFAULT_DIV, div_pending=0, tx counter=DEFAULT_DIV, rx counter=DEFAULT_DIV>>OSR_LOG2.
REQ-025 SHALL hold tx_enable=0 and rx_enable=0 during reset; the first tx pulse occurs on the (D+1)th enabled cycle after reset release.
REQ-026 SHALL, on reset asserted mid-period or with a load pending, discard the pending load and restore the REQ-024 values.

Structure
REQ-027 SHALL place DIV_W, OSR_LOG2 and DEFAULT_DIV defaults in shared package brg_pkg for use by the tx/rx blocks.
REQ-028 SHALL implement both counters as two instances of sub-module brg_down_counter (inputs: enable, reload, reload_value, force, force_value; output: terminal).

Verification
REQ-029 SHALL cover: defaults, enable=1 after reset -> tx_enable every 652 cycles, rx_enable every 41 cycles.
REQ-030 SHALL cover: div_load 16'h0020 mid-period -> div_pending=1 until the current tx period ends, then tx every 33 cycles and rx every 3 cycles.
REQ-031 SHALL cover: div_load coinciding with a tx terminal -> one more old-D period, then the new period.
REQ-032 SHALL cover: D=0x0020, rx_resync pulse -> next rx_enable 2 cycles later (R>>1=1), then every 3 cycles; tx period unchanged.
REQ-033 SHALL cover: enable low for 10 cycles mid-period -> no pulses, and the period resumes extended by exactly 10 cycles.
REQ-034 SHALL cover: rst_n asserted with a load pending -> div_pending=0, D=0x028B, and pulses per REQ-029 after release.

Source files
------------

// File: rtl/brg_pkg.sv
// rtl/brg_pkg.sv - shared defaults for the baud-rate generator
package brg_pkg;

  localparam int          BRG_DIV_W       = 16;
  localparam int          BRG_OSR_LOG2    = 4;
  localparam logic [15:0] BRG_DEFAULT_DIV = 16'h028B;

endpackage

// File: rtl/brg_down_counter.sv
// rtl/brg_down_counter.sv - auto-reloading down counter with terminal flag
// force_load beats reload, reload beats the enabled count/terminal reload.
module brg_down_counter #(
  parameter int           W           = 16,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         reload,
  input  logic [W-1:0] reload_value,
  input  logic         force_load,
  input  logic [W-1:0] force_value,
  output logic         terminal
);

  logic [W-1:0] count;

  assign terminal = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VALUE;
    end else if (force_load) begin
      count <= force_value;
    end else if (reload) begin
      count <= reload_value;
    end else if (enable) begin
      count <= terminal ? reload_value : count - W'(1);
    end
  end

endmodule

// File: rtl/brg_param.sv
// rtl/brg_param.sv - parameterised tx bit-rate / rx oversample pulse generator
// A loaded divisor waits in a pending register and is applied at a tx period boundary.
module brg_param
  import brg_pkg::*;
#(
  parameter int               DIV_W       = BRG_DIV_W,
  parameter int               OSR_LOG2    = BRG_OSR_LOG2,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(BRG_DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             rx_resync,
  output logic             tx_enable,
  output logic             rx_enable,
  output logic             div_pending
);

  localparam logic [DIV_W-1:0] DEFAULT_RX = DEFAULT_DIV >> OSR_LOG2;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_q;
  logic             pend_v;
  logic [DIV_W-1:0] r_cur;
  logic [DIV_W-1:0] r_new;
  logic             tx_term;
  logic             rx_term;
  logic             apply_on;
  logic             apply_off;
  logic             apply;
  logic             resync_go;
  logic             rx_force;
  logic [DIV_W-1:0] rx_force_value;

  assign r_cur = div_q >> OSR_LOG2;
  assign r_new = pend_q >> OSR_LOG2;

  // pend_v is registered, so a load in a terminal cycle is not applied until the next one.
  assign apply_on  = enable & tx_term & pend_v;
  assign apply_off = ~enable & pend_v;
  assign apply     = apply_on | apply_off;
  assign resync_go = enable & rx_resync & ~apply;

  assign rx_force       = apply | resync_go;
  assign rx_force_value = apply ? r_new : (r_cur >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DEFAULT_DIV;
      pend_q <= DEFAULT_DIV;
      pend_v <= 1'b0;
    end else begin
      if (apply) begin
        div_q <= pend_q;
      end
      if (div_load) begin
        pend_q <= div_in;
      end
      pend_v <= div_load | (pend_v & ~apply);
    end
  end

  brg_down_counter #(
    .W           (DIV_W),
    .RESET_VALUE (DEFAULT_DIV)
  ) u_tx_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .reload       (1'b0),
    .reload_value (div_q),
    .force_load   (apply),
    .force_value  (pend_q),
    .terminal     (tx_term)
  );

  brg_down_counter #(
    .W           (DIV_W),
    .RESET_VALUE (DEFAULT_RX)
  ) u_rx_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .reload       (1'b0),
    .reload_value (r_cur),
    .force_load   (rx_force),
    .force_value  (rx_force_value),
    .terminal     (rx_term)
  );

  assign tx_enable   = enable & tx_term;
  assign rx_enable   = enable & rx_term;
  assign div_pending = pend_v;

endmodule

// File: tb/tb_brg_param.sv
// tb/tb_brg_param.sv - self-checking bench for brg_param
module tb_brg_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        div_load;
  logic [15:0] div_in;
  logic        rx_resync;
  logic        tx_enable;
  logic        rx_enable;
  logic        div_pending;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  brg_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .div_load    (div_load),
    .div_in      (div_in),
    .rx_resync   (rx_resync),
    .tx_enable   (tx_enable),
    .rx_enable   (rx_enable),
    .div_pending (div_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: phases count enabled cycles since the last pulse; a pulse fires when phase == divisor.
  int m_d, m_pend, m_tp, m_rp;
  bit m_pv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d = 16'h028B; m_pend = 16'h028B; m_pv = 0; m_tp = 0; m_rp = 0;
    end else begin
      if (enable) begin
        if (m_tp == m_d && m_pv) begin
          m_d = m_pend; m_pv = 0; m_tp = 0; m_rp = 0;
        end else begin
          m_tp = (m_tp == m_d) ? 0 : m_tp + 1;
          if (rx_resync) m_rp = (m_d >> 4) - ((m_d >> 4) >> 1);
          else           m_rp = (m_rp == (m_d >> 4)) ? 0 : m_rp + 1;
        end
      end else if (m_pv) begin
        m_d = m_pend; m_pv = 0; m_tp = 0; m_rp = 0;
      end
      if (div_load) begin
        m_pend = div_in; m_pv = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int last_tx = 0, last_rx = 0, tx_gap = 0, rx_gap = 0, tx_seen = 0, rx_seen = 0;

  always @(negedge clk) begin
    chk("model_tx_enable", {31'd0, tx_enable}, {31'd0, enable && (m_tp == m_d)});
    chk("model_rx_enable", {31'd0, rx_enable}, {31'd0, enable && (m_rp == (m_d >> 4))});
    chk("model_div_pending", {31'd0, div_pending}, {31'd0, m_pv});
    if (tx_enable === 1'b1) begin
      tx_gap = cyc - last_tx; last_tx = cyc; tx_seen++;
    end
    if (rx_enable === 1'b1) begin
      rx_gap = cyc - last_rx; last_rx = cyc; rx_seen++;
    end
  end

  task automatic wait_tx(input int budget = 1000);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (tx_enable !== 1'b1 && n < budget);
    if (tx_enable !== 1'b1) chk("tx_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_rx(input int budget = 200);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (rx_enable !== 1'b1 && n < budget);
    if (rx_enable !== 1'b1) chk("rx_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    div_in = v; div_load = 1'b1;
    @(posedge clk); #1;
    div_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, cr, s;
    rst_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_in = '0; rx_resync = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx_enable}, 32'd0);
    chk("rst_rx", {31'd0, rx_enable}, 32'd0);
    chk("rst_pending", {31'd0, div_pending}, 32'd0);

    // Defaults: 652-cycle tx and 41-cycle rx periods
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 enable = 1'b1; c0 = cyc;
    wait_tx();
    chk("first_tx_offset", last_tx - c0, 32'd651);
    wait_tx();
    chk("tx_period_default", tx_gap, 32'd652);
    wait_rx(); wait_rx();
    chk("rx_period_default", rx_gap, 32'd41);

    // Mid-period load of 0x20
    repeat (100) @(posedge clk);
    #1 load(16'h0020);
    @(negedge clk);
    chk("pending_set", {31'd0, div_pending}, 32'd1);
    wait_tx();
    chk("tx_old_period_end", tx_gap, 32'd652);
    chk("pending_until_term", {31'd0, div_pending}, 32'd1);
    @(negedge clk);
    chk("pending_cleared", {31'd0, div_pending}, 32'd0);
    wait_tx();
    chk("tx_period_0x20", tx_gap, 32'd33);
    wait_rx(); wait_rx();
    chk("rx_period_0x20", rx_gap, 32'd3);

    // Load coinciding with a tx terminal
    wait_tx();
    load(16'h0040);
    wait_tx();
    chk("tx_coincident_old", tx_gap, 32'd33);
    wait_tx();
    chk("tx_coincident_new", tx_gap, 32'd65);

    // Back to 0x20, then rx resync
    @(posedge clk); #1 load(16'h0020);
    wait_tx(); wait_tx();
    chk("tx_period_restore", tx_gap, 32'd33);
    @(posedge clk); #1 rx_resync = 1'b1; cr = cyc;
    @(posedge clk); #1 rx_resync = 1'b0;
    wait_rx();
    chk("resync_first_rx", last_rx - cr, 32'd2);
    wait_rx();
    chk("resync_rx_period", rx_gap, 32'd3);
    wait_tx(); wait_tx();
    chk("resync_tx_period", tx_gap, 32'd33);

    // Enable low for 10 cycles mid-period
    wait_tx();
    repeat (5) @(posedge clk);
    #1 enable = 1'b0; s = tx_seen + rx_seen;
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
    chk("disabled_no_pulses", tx_seen + rx_seen - s, 32'd0);
    wait_tx();
    chk("tx_period_extended", tx_gap, 32'd43);

    // Reset with a load pending
    @(posedge clk); #1 load(16'h0055);
    @(negedge clk);
    chk("pending_before_reset", {31'd0, div_pending}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("reset_clears_pending", {31'd0, div_pending}, 32'd0);
    @(negedge clk);
    chk("reset_tx_low", {31'd0, tx_enable}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; c0 = cyc;
    wait_tx();
    chk("post_reset_first_tx", last_tx - c0, 32'd651);
    wait_tx();
    chk("post_reset_tx_period", tx_gap, 32'd652);
    wait_rx(); wait_rx();
    chk("post_reset_rx_period", rx_gap, 32'd41);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
